// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port 2048x64 data memory between the memory stage (m)
// and the loader port (l), with a central bounds check and starvation protection for l.
module dmem_arbiter #(
   parameter int DEPTH      = 2048,
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m_req,
   input  logic              m_we,
   input  logic [63:0]       m_addr,
   input  logic [DATA_W-1:0] m_wdata,
   output logic              m_ack,
   output logic [DATA_W-1:0] m_rdata,
   output logic              m_err,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [63:0]       l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_ack,
   output logic [DATA_W-1:0] l_rdata,
   output logic              l_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERR} state_t;
   state_t              r_state, w_next;
   logic [SW-1:0]       r_starve;
   logic                r_sel, r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                w_req, w_gnt_l, w_oor, w_ack, w_err;
   logic [63:0]         w_addr;
   logic [DATA_W-1:0]   w_rd;
   assign w_req   = m_req | l_req;
   // l wins when alone, or when m has been granted STARVE_MAX times in a row while l waited
   assign w_gnt_l = l_req & (~m_req | (r_starve == SW'(STARVE_MAX)));
   assign w_addr  = w_gnt_l ? l_addr : m_addr;
   assign w_oor   = w_addr > 64'(DEPTH - 1);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_starve <= '0;
         r_sel    <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE) begin
            r_starve <= (!l_req || w_gnt_l) ? '0 :
                        (r_starve == SW'(STARVE_MAX)) ? r_starve : r_starve + SW'(1);
            if (w_req) begin
               r_sel   <= w_gnt_l;
               r_we    <= w_gnt_l ? l_we : m_we;
               r_addr  <= w_addr[ADDR_W-1:0];
               r_wdata <= w_gnt_l ? l_wdata : m_wdata;
            end
         end
      end
   end
   // outputs are gated by rst_n so nothing reaches memory or the requesters during reset
   always_comb begin
      w_next = IDLE;
      if (r_state == IDLE && w_req) w_next = w_oor ? ERR : ISSUE;
      else if (r_state == ISSUE) w_next = RESP;
      w_ack     = rst_n & (r_state == RESP || r_state == ERR);
      w_err     = rst_n & (r_state == ERR);
      w_rd      = (rst_n && r_state == RESP && !r_we) ? mem_rdata : '0;
      m_ack     = w_ack & ~r_sel;
      l_ack     = w_ack & r_sel;
      m_err     = w_err & ~r_sel;
      l_err     = w_err & r_sel;
      m_rdata   = r_sel ? '0 : w_rd;
      l_rdata   = r_sel ? w_rd : '0;
      mem_en    = rst_n & (r_state == ISSUE);
      mem_we    = mem_en & r_we;
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
      busy      = rst_n & (r_state != IDLE);
   end
endmodule
